serial_word_tx: RTL
===================

Name: serial_word_tx

Overview:
- Parallel-to-serial transmitter that drives the bit-serial two's-complement datapath.
- Accepts a WIDTH-bit word over a valid/ready handshake and emits it LSB first, one bit per t_clk cycle.
- Marks the first bit of each word with a start strobe, which is the per-word reset the serial complementer expects.
- A one-entry holding buffer allows back-to-back words with no idle bit between them.

Parameters:
- WIDTH, 8, word length in bits; legal range 2..32.
- GAP, 0, number of idle bit-times inserted after each word; legal range 0..15.

Ports:
- t_clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset; one clock; reset is asynchronous and active-low.
- din  in  WIDTH  parallel word to transmit.
- din_valid  in  1  din holds a word.
- din_ready  out  1  transmitter can accept a word; a transfer occurs on an edge where din_valid && din_ready.
- ser_bit  out  1  serial data, LSB first (drives the complementer's data input).
- ser_start  out  1  high only during bit 0 of a word (drives the complementer's word-start input).
- ser_valid  out  1  high while a word bit is on ser_bit.
- busy  out  1  shifter active, in gap, or holding buffer occupied.

Behaviour:
- Reset values: din_ready=1, ser_bit=0, ser_start=0, ser_valid=0, busy=0. State=IDLE, bit_cnt=0, hold buffer empty.
- Reset asserted mid-word drops the word in flight and the held word. Outputs go to reset values immediately, without waiting for a clock edge.
- All outputs are registered except din_ready, which is !hold_valid.
- State IDLE:
  - ser_valid=0, ser_bit=0.
  - On an accepted transfer, or with the hold buffer full, load the word into the shifter and go to SHIFT.
  - Hold takes priority over din; a transfer on that edge then lands in hold.
- State SHIFT:
  - ser_bit=shift[0], ser_valid=1, ser_start=(bit_cnt==0).
  - Each edge: shift right by 1 and increment bit_cnt.
- Last bit (bit_cnt==WIDTH-1):
  - GAP>0: go to GAP state.
  - GAP==0 and a word is available (hold full, or a transfer on this edge when hold is empty): load it and stay in SHIFT with bit_cnt=0. The next bit is bit 0 of the new word with ser_start=1 (zero-bubble).
  - Otherwise: go to IDLE.
- State GAP:
  - Outputs as in IDLE for GAP cycles, counted by gap_cnt.
  - Then: if a word is available, go to SHIFT; else go to IDLE.
- Latency: transfer at edge k with the shifter idle and hold empty gives bit 0 on the outputs after edge k; the word occupies WIDTH cycles.
- Hold buffer:
  - A transfer writes hold when the shifter is busy and not simultaneously consuming the word at this edge.
  - A simultaneous load-from-hold and new transfer is allowed; hold stays full with the new word.
- din is sampled only on transfer edges; changes at other times are ignored.
- busy = (state!=IDLE) || hold_valid.

Decomposition:
- Shared package/include serial_defs: state encodings (IDLE=2'd0, SHIFT=2'd1, GAP=2'd2) and the default WIDTH constant. The complementer and any future serial blocks reuse these.
- One sub-module, ser_shift_reg: WIDTH-bit load/shift-right register with bit counter and last-bit flag.
- Handshake, hold buffer and FSM stay in the top module.

Test Plan:
- Single word, WIDTH=8, GAP=0: din=8'hB4 for one cycle.
  -> ser_bit = 0,0,1,0,1,1,0,1 on 8 consecutive cycles.
  -> ser_start=1 on the first cycle only; ser_valid=1 for exactly 8 cycles; then IDLE with ser_bit=0.
- Back-to-back: 8'h01, 8'h80, 8'hFF offered continuously.
  -> 24 contiguous ser_valid cycles; ser_start high on cycles 0, 8 and 16.
  -> din_ready low once hold fills; no word dropped or duplicated.
- Backpressure: hold full while shifting.
  -> din_ready=0; din changes while not ready are ignored.
  -> din_ready rises the cycle after hold moves into the shifter.
- GAP=2: two words 8'h0F, 8'hF0 queued.
  -> Exactly 2 cycles with ser_valid=0 between the words; ser_start marks the first bit of each.
- Reset mid-word: assert rst_n=0 during bit 3 of 8'hAA, with another word in hold.
  -> Outputs go to reset values immediately.
  -> After release, idle and din_ready=1; no remnant bits of either word appear.
- End-to-end: drive the complementer from ser_bit/ser_start, send 8'h05, collect 8 output bits LSB first -> 8'hFB. Then send 8'h00 -> 8'h00.

Source files
------------

// File: rtl/serial_defs_pkg.sv
// Shared definitions for the bit-serial datapath blocks (transmitter, complementer, ...).
// State encodings are fixed so checkers and neighbouring blocks can decode them.
package serial_defs_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } ser_state_t;

  localparam int SER_WIDTH_DEFAULT = 8;

endpackage

// File: rtl/ser_shift_reg.sv
// WIDTH-bit load / shift-right register with a bit counter and last-bit flag.
// Load has priority over advance; the counter restarts at zero after the last bit.
module ser_shift_reg
  import serial_defs_pkg::*;
#(
  parameter int WIDTH = SER_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             advance,
  output logic             next_lsb,
  output logic             last
);

  localparam int CNT_W = $clog2(WIDTH);

  logic [WIDTH-1:0] shift;
  logic [CNT_W-1:0] bit_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift   <= '0;
      bit_cnt <= '0;
    end else if (load) begin
      shift   <= load_data;
      bit_cnt <= '0;
    end else if (advance) begin
      shift   <= shift >> 1;
      bit_cnt <= last ? '0 : bit_cnt + CNT_W'(1);
    end
  end

  // Bit that will be on the line after the next advance.
  assign next_lsb = shift[1];
  assign last     = (bit_cnt == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/serial_word_tx.sv
// Parallel-to-serial word transmitter, LSB first, with a one-entry hold buffer
// for zero-bubble back-to-back words and an optional idle gap after each word.
module serial_word_tx
  import serial_defs_pkg::*;
#(
  parameter int WIDTH = SER_WIDTH_DEFAULT,
  parameter int GAP   = 0
) (
  input  logic             t_clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             ser_bit,
  output logic             ser_start,
  output logic             ser_valid,
  output logic             busy
);

  // Handshake: a word transfers on a rising edge where din_valid && din_ready;
  // din_ready depends only on the hold buffer, never on din_valid.

  localparam logic [3:0] GAP_LAST = 4'((GAP > 0) ? GAP - 1 : 0);

  ser_state_t       state, state_nxt;
  logic [WIDTH-1:0] hold_data;
  logic [WIDTH-1:0] load_data;
  logic             hold_valid, hold_valid_nxt, hold_write;
  logic [3:0]       gap_cnt;
  logic             xfer, word_avail, take, gap_done;
  logic             next_lsb, last;

  assign din_ready  = !hold_valid;
  assign xfer       = din_valid && din_ready;
  assign word_avail = hold_valid || xfer;
  assign load_data  = hold_valid ? hold_data : din;
  assign gap_done   = (gap_cnt == GAP_LAST);

  ser_shift_reg #(.WIDTH(WIDTH)) u_shift (
    .clk      (t_clk),
    .rst_n    (rst_n),
    .load     (take),
    .load_data(load_data),
    .advance  (state == ST_SHIFT),
    .next_lsb (next_lsb),
    .last     (last)
  );

  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (word_avail) begin
          take      = 1'b1;
          state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (last) begin
          if (GAP > 0)         state_nxt = ST_GAP;
          else if (word_avail) take      = 1'b1;
          else                 state_nxt = ST_IDLE;
        end
      end
      ST_GAP: begin
        if (gap_done) begin
          if (word_avail) begin
            take      = 1'b1;
            state_nxt = ST_SHIFT;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    // A transfer bypasses hold only when the shifter consumes it directly.
    hold_write     = xfer && !(take && !hold_valid);
    hold_valid_nxt = (hold_valid && !take) || hold_write;
  end

  always_ff @(posedge t_clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      hold_valid <= 1'b0;
      hold_data  <= '0;
      gap_cnt    <= '0;
      ser_bit    <= 1'b0;
      ser_start  <= 1'b0;
      ser_valid  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      hold_valid <= hold_valid_nxt;
      if (hold_write) hold_data <= din;
      gap_cnt    <= (state == ST_GAP) ? gap_cnt + 4'd1 : 4'd0;
      ser_valid  <= (state_nxt == ST_SHIFT);
      ser_start  <= take;
      ser_bit    <= take ? load_data[0] : ((state_nxt == ST_SHIFT) && next_lsb);
      busy       <= (state_nxt != ST_IDLE) || hold_valid_nxt;
    end
  end

endmodule
